// File: rtl/sat_accum_alu_if.sv
// Operand/result bus for sat_accum_alu: valid/ready on both the input beat and the
// registered result, plus the accumulator clear and the status flags.
interface sat_accum_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             sat;
  logic             sticky_ovf;

  modport master (
    output in_valid, op, a, b, acc_clear, out_ready,
    input  in_ready, out_valid, result, carry, sat, sticky_ovf
  );

  modport slave (
    input  in_valid, op, a, b, acc_clear, out_ready,
    output in_ready, out_valid, result, carry, sat, sticky_ovf
  );
endinterface

// File: rtl/sat_accum_alu.sv
// Registered unsigned add/sub/accumulate/load unit with optional saturation,
// a single output register and a sticky overflow flag.
module sat_accum_alu #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  sat_accum_alu_if.slave   bus,
  output logic [WIDTH-1:0] o_dbg_acc
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_sat;
  logic [WIDTH-1:0] r_acc;
  logic             r_sticky;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH:0]   w_raw;
  logic             w_carry;
  logic             w_sat;
  logic [WIDTH-1:0] w_result;
  logic             w_acc_write;

  // Handshake: a beat transfers on any rising edge where valid && ready. The input
  // side is ready whenever the output register is empty or being drained this cycle;
  // a held result (out_valid && !out_ready) stays stable and blocks new beats.
  assign w_in_ready  = !r_out_valid || bus.out_ready;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_acc_write = w_accept && ((bus.op == OP_ACC) || (bus.op == OP_LOAD));

  always_comb begin
    w_acc_base = bus.acc_clear ? '0 : r_acc;
    w_raw      = {1'b0, bus.a} + {1'b0, bus.b};
    case (bus.op)
      OP_ADD:  w_raw = {1'b0, bus.a} + {1'b0, bus.b};
      OP_SUB:  w_raw = {1'b0, bus.a} - {1'b0, bus.b};
      OP_ACC:  w_raw = {1'b0, w_acc_base} + {1'b0, bus.a};
      OP_LOAD: w_raw = {1'b0, bus.a};
      default: w_raw = {1'b0, bus.a} + {1'b0, bus.b};
    endcase
  end

  // The top bit of the widened subtract is the borrow (a < b); LOAD never sets it.
  always_comb begin
    w_carry  = w_raw[WIDTH];
    w_sat    = SATURATE && w_carry;
    w_result = w_raw[WIDTH-1:0];
    if (w_sat) begin
      w_result = (bus.op == OP_SUB) ? '0 : '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_sat       <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_result    <= w_result;
      r_carry     <= w_carry;
      r_sat       <= w_sat;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Clear is applied before the new op, so an accepted op only sees its own carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (w_acc_write) begin
        r_acc <= w_result;
      end else if (bus.acc_clear) begin
        r_acc <= '0;
      end
      if (w_accept && w_carry) begin
        r_sticky <= 1'b1;
      end else if (bus.acc_clear) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.result     = r_result;
  assign bus.carry      = r_carry;
  assign bus.sat        = r_sat;
  assign bus.sticky_ovf = r_sticky;
  assign o_dbg_acc      = r_acc;

endmodule
